// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: opcode slots in, stall flags and stall-cycle count out
interface hazard_detection_unit_if #(
   parameter int OPCODE_W = 4,
   parameter int CNT_W    = 16
);
   logic [OPCODE_W-1:0] current_opcode;
   logic [OPCODE_W-1:0] previous_opcode;
   logic [OPCODE_W-1:0] previous_previous_opcode;
   logic                stall_current;
   logic                stall_previous;
   logic                stall_any;
   logic [CNT_W-1:0]    stall_cycles;
   modport master (
      output current_opcode, previous_opcode, previous_previous_opcode,
      input  stall_current, stall_previous, stall_any, stall_cycles
   );
   modport slave (
      input  current_opcode, previous_opcode, previous_previous_opcode,
      output stall_current, stall_previous, stall_any, stall_cycles
   );
endinterface

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: combinational stall flags plus a saturating stall-cycle counter
module hazard_detection_unit #(
   parameter int                  OPCODE_W   = 4,
   parameter logic [OPCODE_W-1:0] HAZ_OPCODE = 4'b1010,
   parameter int                  CNT_W      = 16
) (
   input logic                     clk,
   input logic                     rst_n,
   hazard_detection_unit_if.slave  bus
);
   logic [CNT_W-1:0] cnt;
   always_comb begin
      bus.stall_current  = rst_n && (bus.current_opcode == HAZ_OPCODE);
      bus.stall_previous = rst_n && ((bus.previous_opcode == HAZ_OPCODE) ||
                                     (bus.previous_previous_opcode == HAZ_OPCODE));
      bus.stall_any      = bus.stall_current || bus.stall_previous;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (bus.stall_any && cnt != '1) cnt <= cnt + 1'b1;
   assign bus.stall_cycles = cnt;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: randomized scoreboard bench for 16-bit and 4-bit counter variants
module tb_hazard_detection_unit;
   localparam logic [3:0] HAZ = 4'b1010;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_detection_unit_if #(.OPCODE_W(4), .CNT_W(16)) i16 ();
   hazard_detection_unit_if #(.OPCODE_W(4), .CNT_W(4))  i4 ();

   hazard_detection_unit #(.OPCODE_W(4), .HAZ_OPCODE(HAZ), .CNT_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(i16.slave));
   hazard_detection_unit #(.OPCODE_W(4), .HAZ_OPCODE(HAZ), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(i4.slave));

   typedef struct {
      logic cur, prv, any;
      int   c16, c4;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   n = 0;
   logic prev_any = 1'b0;
   bit   done = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: count = stall cycles seen since last reset, clipped at the counter maximum
   task automatic step(input logic [3:0] c, input logic [3:0] p, input logic [3:0] pp, input logic r);
      exp_t e;
      @(posedge clk);
      if (rst_n && prev_any) n++;
      #1;
      rst_n = r;
      i16.current_opcode = c; i16.previous_opcode = p; i16.previous_previous_opcode = pp;
      i4.current_opcode  = c; i4.previous_opcode  = p; i4.previous_previous_opcode  = pp;
      if (!r) n = 0;
      e.cur = r && (c == HAZ);
      e.prv = r && (p == HAZ || pp == HAZ);
      e.any = e.cur || e.prv;
      e.c16 = n > 65535 ? 65535 : n;
      e.c4  = n > 15 ? 15 : n;
      prev_any = e.any;
      q.push_back(e);
   endtask

   function automatic logic [3:0] rnd_op();
      return ($urandom_range(0, 2) == 0) ? HAZ : 4'($urandom);
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("stall_current",  int'(i16.stall_current),  int'(e.cur));
            check("stall_previous", int'(i16.stall_previous), int'(e.prv));
            check("stall_any",      int'(i16.stall_any),      int'(e.any));
            check("stall_cycles16", int'(i16.stall_cycles),   e.c16);
            check("stall_cycles4",  int'(i4.stall_cycles),    e.c4);
            check("flags4_any",     int'(i4.stall_any),       int'(e.any));
         end
      end
   end

   initial begin
      i16.current_opcode = '0; i16.previous_opcode = '0; i16.previous_previous_opcode = '0;
      i4.current_opcode  = '0; i4.previous_opcode  = '0; i4.previous_previous_opcode  = '0;
      step(0, 0, 0, 0);
      step(HAZ, HAZ, HAZ, 0);
      repeat (3) step(0, 0, 0, 1);
      repeat (3) step(HAZ, 0, 0, 1);
      repeat (2) step(0, HAZ, 0, 1);
      repeat (2) step(0, 0, HAZ, 1);
      repeat (2) step(HAZ, HAZ, HAZ, 1);
      repeat (3) step(4'b1011, 4'b0010, 4'b1110, 1);
      repeat (20) step(HAZ, 0, 0, 1);
      step(HAZ, HAZ, 0, 0);
      step(0, 0, 0, 1);
      for (int i = 0; i < 300; i++)
         step(rnd_op(), rnd_op(), rnd_op(), $urandom_range(0, 40) != 0);
      repeat (25) step(0, 0, HAZ, 1);
      step(4'b1011, 0, 0, 1);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left expected 0", q.size());
      end
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Pipeline hazard detector for the CPU. It compares the opcodes in the current, previous and previous-previous pipeline slots against the hazard-class opcode (4'b1010).
- Stall flags are combinational (zero latency) so the pipeline control can act in the same cycle.
- A clocked, saturating stall-cycle counter supports performance and debug visibility.

Parameters:
- OPCODE_W, 4, width of every opcode input.
- HAZ_OPCODE, 4'b1010, the opcode that triggers a stall.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- current_opcode  input  OPCODE_W  opcode of the instruction in the current stage.
- previous_opcode  input  OPCODE_W  opcode one stage ahead.
- previous_previous_opcode  input  OPCODE_W  opcode two stages ahead.
- stall_current  output  1  stall request caused by the current instruction.
- stall_previous  output  1  stall request caused by either older instruction.
- stall_any  output  1  OR of stall_current and stall_previous.
- stall_cycles  output  CNT_W  saturating count of clock cycles with stall_any=1.

Behaviour:
- stall_current = (current_opcode == HAZ_OPCODE).
- stall_previous = (previous_opcode == HAZ_OPCODE) OR (previous_previous_opcode == HAZ_OPCODE).
- stall_any = stall_current OR stall_previous.
- All three flags are purely combinational from the opcode inputs, with zero latency. They settle within the same delta/cycle and are independent of clk.
- While rst_n=0, stall_current, stall_previous and stall_any are forced to 0 regardless of the opcodes. On rst_n deassertion they follow the inputs immediately.
- Flags are independent: any combination of the two may be 1 simultaneously. For example, all three opcodes equal to HAZ_OPCODE gives both flags 1.
- Only an exact match triggers a flag. Every other opcode value, including 4'b1011 and 4'b0010, produces no stall.
- X/Z handling is not required. Inputs are assumed driven. The bench compares with ===, so outputs must be clean 0/1 for driven inputs.
- stall_cycles behaviour:
  - Reset: asynchronously cleared to 0 when rst_n falls; stays 0 while rst_n=0.
  - Rising clk with rst_n=1: increments by 1 if stall_any=1, otherwise holds.
  - Saturation: holds at all-ones (2^CNT_W-1) and never wraps.
  - Mid-operation reset: an rst_n assertion clears the count immediately (asynchronously).
- No handshake, FSM or internal pipeline registers other than stall_cycles.

Test Plan:
- Reset then idle: rst_n=0, then 1; all opcodes 4'b0000; wait 10 ns -> stall_current=0, stall_previous=0, stall_any=0, stall_cycles=0.
- Current hazard: current=4'b1010, previous=0, prev_prev=0 -> stall_current=1, stall_previous=0 within the same delta. stall_cycles increments by 1 per rising edge.
- Previous hazard: current=0, previous=4'b1010, prev_prev=0 -> stall_current=0, stall_previous=1.
- Previous-previous hazard: current=0, previous=0, prev_prev=4'b1010 -> stall_current=0, stall_previous=1.
- Multiple hazards and near-miss opcodes:
  - All three opcodes = 4'b1010 -> both flags 1.
  - Opcodes 4'b1011/4'b0010/4'b1110 -> both flags 0 and the counter holds.
- Counter saturation and reset:
  - Set CNT_W=4 and hold a hazard for 20 cycles -> stall_cycles=4'hF and stays there.
  - Pull rst_n low between clock edges -> count=0 and flags=0 immediately.
